// File: rtl/enigma_pkg.sv
// enigma_pkg: shared constants, FSM state type and wrap-increment helper
// for the Enigma rotor sequencer.
package enigma_pkg;

    localparam int LETTER_W   = 5;
    localparam int ALPHA      = 26;
    localparam int NOTCH1_DEF = 16;  // 'Q'
    localparam int NOTCH2_DEF = 4;   // 'E'

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        STEP = 2'd1,
        ENC  = 2'd2
    } state_e;

    // Increment with explicit compare-and-clear at the top of the alphabet.
    function automatic logic [LETTER_W-1:0] inc_wrap(
        input logic [LETTER_W-1:0] x,
        input logic [LETTER_W-1:0] last
    );
        return (x == last) ? '0 : x + 1'b1;
    endfunction

endpackage

// File: rtl/enigma_step_ctrl_rotor_stepper.sv
// rotor_stepper: combinational next-position logic for three rotors.
//   r1_i..r3_i : current positions
//   r1_o..r3_o : positions after one keypress (increment, wrap, double-step)
module rotor_stepper
    import enigma_pkg::*;
#(
    parameter int ALPHA  = enigma_pkg::ALPHA,
    parameter int NOTCH1 = NOTCH1_DEF,
    parameter int NOTCH2 = NOTCH2_DEF
) (
    input  logic [LETTER_W-1:0] r1_i,
    input  logic [LETTER_W-1:0] r2_i,
    input  logic [LETTER_W-1:0] r3_i,
    output logic [LETTER_W-1:0] r1_o,
    output logic [LETTER_W-1:0] r2_o,
    output logic [LETTER_W-1:0] r3_o
);

    localparam logic [LETTER_W-1:0] LAST = LETTER_W'(ALPHA - 1);
    localparam logic [LETTER_W-1:0] N1   = LETTER_W'(NOTCH1);
    localparam logic [LETTER_W-1:0] N2   = LETTER_W'(NOTCH2);

    logic carry1;  // r1 leaving its notch carries into r2
    logic carry2;  // r2 sitting on its notch steps itself and r3

    assign carry1 = (r1_i == N1);
    assign carry2 = (r2_i == N2);

    assign r1_o = inc_wrap(r1_i, LAST);
    // r2 also steps when it is on its own notch: the double-step anomaly.
    assign r2_o = (carry1 || carry2) ? inc_wrap(r2_i, LAST) : r2_i;
    assign r3_o = carry2 ? inc_wrap(r3_i, LAST) : r3_i;

endmodule

// File: rtl/enigma_step_ctrl.sv
// enigma_step_ctrl: keypress sequencer for the combinational Enigma datapath.
//   clk, rst          : clock, synchronous active-high reset
//   key_valid, key_in : plaintext letter request (one-cycle pulse)
//   cfg_load, cfg_r*  : rotor start-position load (one-cycle pulse)
//   enc_out           : ciphertext returned by the datapath
//   enc_in, r1..r3    : letter and rotor positions driven to the datapath
//   out_valid/out_char: registered ciphertext with one-cycle valid pulse
//   busy              : FSM not idle
//   err               : registered pulse, a request was rejected
module enigma_step_ctrl
    import enigma_pkg::*;
#(
    parameter int ALPHA  = enigma_pkg::ALPHA,
    parameter int NOTCH1 = NOTCH1_DEF,
    parameter int NOTCH2 = NOTCH2_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                key_valid,
    input  logic [LETTER_W-1:0] key_in,
    input  logic                cfg_load,
    input  logic [LETTER_W-1:0] cfg_r1,
    input  logic [LETTER_W-1:0] cfg_r2,
    input  logic [LETTER_W-1:0] cfg_r3,
    input  logic [LETTER_W-1:0] enc_out,
    output logic [LETTER_W-1:0] enc_in,
    output logic [LETTER_W-1:0] r1,
    output logic [LETTER_W-1:0] r2,
    output logic [LETTER_W-1:0] r3,
    output logic                out_valid,
    output logic [LETTER_W-1:0] out_char,
    output logic                busy,
    output logic                err
);

    localparam logic [LETTER_W-1:0] LAST = LETTER_W'(ALPHA - 1);

    state_e              state_q, state_d;
    logic [LETTER_W-1:0] r1_q, r1_d, r2_q, r2_d, r3_q, r3_d;
    logic [LETTER_W-1:0] enc_in_q, enc_in_d;
    logic [LETTER_W-1:0] out_char_q, out_char_d;
    logic                out_valid_q, out_valid_d;
    logic                err_q, err_d;
    logic [LETTER_W-1:0] r1_nx, r2_nx, r3_nx;
    logic                cfg_ok;

    rotor_stepper #(
        .ALPHA (ALPHA),
        .NOTCH1(NOTCH1),
        .NOTCH2(NOTCH2)
    ) u_stepper (
        .r1_i(r1_q),
        .r2_i(r2_q),
        .r3_i(r3_q),
        .r1_o(r1_nx),
        .r2_o(r2_nx),
        .r3_o(r3_nx)
    );

    assign cfg_ok = (cfg_r1 <= LAST) && (cfg_r2 <= LAST) && (cfg_r3 <= LAST);

    always_comb begin
        state_d     = state_q;
        r1_d        = r1_q;
        r2_d        = r2_q;
        r3_d        = r3_q;
        enc_in_d    = enc_in_q;
        out_char_d  = out_char_q;
        out_valid_d = 1'b0;
        err_d       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (cfg_load) begin
                    // Load has priority; a simultaneous key is dropped and flagged.
                    if (cfg_ok) begin
                        r1_d = cfg_r1;
                        r2_d = cfg_r2;
                        r3_d = cfg_r3;
                    end
                    err_d = !cfg_ok || key_valid;
                end else if (key_valid) begin
                    if (key_in <= LAST) begin
                        enc_in_d = key_in;
                        state_d  = STEP;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            STEP: begin
                r1_d    = r1_nx;
                r2_d    = r2_nx;
                r3_d    = r3_nx;
                err_d   = key_valid || cfg_load;
                state_d = ENC;
            end
            ENC: begin
                // Datapath has had this full cycle to settle on the new rotors.
                out_char_d  = enc_out;
                out_valid_d = 1'b1;
                err_d       = key_valid || cfg_load;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            r1_q        <= '0;
            r2_q        <= '0;
            r3_q        <= '0;
            enc_in_q    <= '0;
            out_char_q  <= '0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            r1_q        <= r1_d;
            r2_q        <= r2_d;
            r3_q        <= r3_d;
            enc_in_q    <= enc_in_d;
            out_char_q  <= out_char_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
        end
    end

    assign enc_in    = enc_in_q;
    assign r1        = r1_q;
    assign r2        = r2_q;
    assign r3        = r3_q;
    assign out_char  = out_char_q;
    assign out_valid = out_valid_q;
    assign err       = err_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_enigma_step_ctrl.sv
module tb_enigma_step_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_valid = 1'b0;
    logic [4:0] key_in = '0;
    logic       cfg_load = 1'b0;
    logic [4:0] cfg_r1 = '0, cfg_r2 = '0, cfg_r3 = '0;
    logic [4:0] enc_out;
    logic [4:0] enc_in, r1, r2, r3, out_char;
    logic       out_valid, busy, err;

    int checks = 0;
    int errors = 0;
    int n_pushed = 0;
    int n_seen = 0;

    typedef struct {
        int ch;
        int a;
        int b;
        int c;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    enigma_step_ctrl dut (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key_in(key_in),
        .cfg_load(cfg_load), .cfg_r1(cfg_r1), .cfg_r2(cfg_r2), .cfg_r3(cfg_r3),
        .enc_out(enc_out), .enc_in(enc_in), .r1(r1), .r2(r2), .r3(r3),
        .out_valid(out_valid), .out_char(out_char), .busy(busy), .err(err)
    );

    // Stand-in combinational datapath: a simple position-dependent shift.
    function automatic int model_enc(input int k, input int a, input int b, input int c);
        return (k + a + 2 * b + 3 * c) % 26;
    endfunction

    always_comb enc_out = 5'(model_enc(int'(enc_in), int'(r1), int'(r2), int'(r3)));

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    // Monitor: every out_valid pulse must match the oldest expected result.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            n_seen++;
            if (exp_q.size() == 0) begin
                chk("unexpected_out_valid", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("out_char", int'(out_char), e.ch);
                chk("out_r1", int'(r1), e.a);
                chk("out_r2", int'(r2), e.b);
                chk("out_r3", int'(r3), e.c);
            end
        end
    end

    task automatic cfg(input int a, input int b, input int c,
                       input int exp_err, input int ea, input int eb, input int ec);
        @(posedge clk); #1;
        cfg_load = 1'b1; cfg_r1 = 5'(a); cfg_r2 = 5'(b); cfg_r3 = 5'(c);
        @(posedge clk); #1;
        cfg_load = 1'b0;
        chk("cfg_err", int'(err), exp_err);
        chk("cfg_r1", int'(r1), ea);
        chk("cfg_r2", int'(r2), eb);
        chk("cfg_r3", int'(r3), ec);
    endtask

    // Issue a key and check the k / k+1 / k+2 timing; a,b,c are the
    // hand-computed rotor positions after stepping.
    task automatic key(input int k, input int a, input int b, input int c);
        exp_t e;
        @(posedge clk); #1;
        key_valid = 1'b1; key_in = 5'(k);
        e.ch = model_enc(k, a, b, c); e.a = a; e.b = b; e.c = c;
        exp_q.push_back(e);
        n_pushed++;
        @(posedge clk); #1;                       // edge k
        key_valid = 1'b0;
        chk("busy_k", int'(busy), 1);
        @(posedge clk); #1;                       // edge k+1
        chk("ov_k1", int'(out_valid), 0);
        chk("step_r1", int'(r1), a);
        chk("step_r2", int'(r2), b);
        chk("step_r3", int'(r3), c);
        @(posedge clk); #1;                       // edge k+2
        chk("ov_k2", int'(out_valid), 1);
        chk("busy_k2", int'(busy), 0);
    endtask

    initial begin
        // Reset
        repeat (2) @(posedge clk);
        #1;
        chk("rst_r1", int'(r1), 0);
        chk("rst_r2", int'(r2), 0);
        chk("rst_r3", int'(r3), 0);
        chk("rst_enc_in", int'(enc_in), 0);
        chk("rst_out_char", int'(out_char), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_err", int'(err), 0);
        rst = 1'b0;

        cfg(0, 0, 0, 0, 0, 0, 0);
        key(0, 1, 0, 0);
        @(posedge clk); #1;
        chk("out_char_hold", int'(out_char), 1);

        // Notch carry / no carry
        cfg(16, 0, 0, 0, 16, 0, 0);
        key(5, 17, 1, 0);
        cfg(15, 0, 0, 0, 15, 0, 0);
        key(5, 16, 0, 0);

        // Double-step
        cfg(16, 3, 0, 0, 16, 3, 0);
        key(7, 17, 4, 0);
        key(8, 18, 5, 1);
        key(9, 19, 5, 1);

        // Wrap
        cfg(25, 25, 25, 0, 25, 25, 25);
        key(11, 0, 25, 25);
        cfg(16, 4, 25, 0, 16, 4, 25);
        key(12, 17, 5, 0);

        // Reject: letter out of range
        @(posedge clk); #1;
        key_valid = 1'b1; key_in = 5'd26;
        @(posedge clk); #1;
        key_valid = 1'b0;
        chk("badkey_err", int'(err), 1);
        chk("badkey_busy", int'(busy), 0);
        chk("badkey_r1", int'(r1), 17);
        @(posedge clk); #1;
        chk("badkey_err_pulse", int'(err), 0);

        // Reject: position out of range
        cfg(3, 30, 3, 1, 17, 5, 0);

        // Reject: key while in STEP
        cfg(1, 2, 3, 0, 1, 2, 3);
        @(posedge clk); #1;
        key_valid = 1'b1; key_in = 5'd4;
        exp_q.push_back('{model_enc(4, 2, 2, 3), 2, 2, 3});
        n_pushed++;
        @(posedge clk); #1;                       // accepted, now STEP
        key_in = 5'd9;
        @(posedge clk); #1;                       // STEP saw a key
        key_valid = 1'b0;
        chk("busy_key_err", int'(err), 1);
        chk("busy_key_r1", int'(r1), 2);
        repeat (3) @(posedge clk);
        #1;

        // cfg_load and key together
        @(posedge clk); #1;
        cfg_load = 1'b1; cfg_r1 = 5'd2; cfg_r2 = 5'd3; cfg_r3 = 5'd4;
        key_valid = 1'b1; key_in = 5'd1;
        @(posedge clk); #1;
        cfg_load = 1'b0; key_valid = 1'b0;
        chk("both_err", int'(err), 1);
        chk("both_busy", int'(busy), 0);
        chk("both_r1", int'(r1), 2);
        chk("both_r2", int'(r2), 3);
        chk("both_r3", int'(r3), 4);

        // Reset mid-operation
        cfg(5, 6, 7, 0, 5, 6, 7);
        @(posedge clk); #1;
        key_valid = 1'b1; key_in = 5'd3;
        @(posedge clk); #1;                       // now STEP
        key_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_r1", int'(r1), 0);
        chk("midrst_r2", int'(r2), 0);
        chk("midrst_r3", int'(r3), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_ov", int'(out_valid), 0);
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("midrst_busy_after", int'(busy), 0);

        chk("pending_results", exp_q.size(), 0);
        chk("out_valid_count", n_seen, n_pushed);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/enigma_step_ctrl.md
# enigma_step_ctrl

Sequencer for the combinational `encryption` datapath on the Basys3 Enigma machine. It accepts one plaintext letter per keypress, advances the three rotor positions with Enigma stepping (including the middle-rotor double-step), and drives the datapath. It then registers the ciphertext letter with a one-cycle valid pulse. It also owns rotor position loading from the board switches.

## Interface

Parameters:
- `ALPHA`, default 26: alphabet size. Legal positions and letters are 0..ALPHA-1.
- `NOTCH1`, default 16: r1 position ('Q') whose step also steps r2.
- `NOTCH2`, default 4: r2 position ('E') that causes the double-step.

Ports:
- `clk`, input, 1: system clock.
- `rst`, input, 1: synchronous, active-high reset.
- `key_valid`, input, 1: one-cycle pulse; `key_in` is valid.
- `key_in`, input, 5: plaintext letter.
- `cfg_load`, input, 1: one-cycle pulse; load rotor start positions.
- `cfg_r1`, `cfg_r2`, `cfg_r3`, input, 5 each: start positions.
- `enc_out`, input, 5: ciphertext from the datapath.
- `enc_in`, output, 5: letter presented to the datapath.
- `r1`, `r2`, `r3`, output, 5 each: current rotor positions. These feed both the datapath and the display.
- `out_valid`, output, 1: one-cycle pulse; `out_char` is new.
- `out_char`, output, 5: registered ciphertext. Holds its value until the next result.
- `busy`, output, 1: high when not in IDLE.
- `err`, output, 1: one-cycle pulse; a request was rejected.

## Operation

- FSM states: IDLE → STEP → ENC → IDLE.
- **IDLE, `cfg_load`=1:** if all three `cfg_r*` are below ALPHA, load r1/r2/r3. Otherwise, leave the rotors unchanged and pulse `err`. If `key_valid` is high in the same cycle, `cfg_load` wins, the key is dropped, and `err` pulses.
- **IDLE, `key_valid`=1, `key_in` < ALPHA:** capture `key_in` into `enc_in` and go to STEP.
- **IDLE, `key_valid`=1, `key_in` ≥ ALPHA:** no state change; pulse `err`.
- **STEP:** all rotors update in a single cycle, using the old values:
  - r1 ← r1+1 (mod ALPHA).
  - r2 ← r2+1 if old r1==NOTCH1 or old r2==NOTCH2 (the double-step).
  - r3 ← r3+1 if old r2==NOTCH2.
  - Go to ENC.
- **ENC:** `enc_in` and the new r1..r3 are stable for the datapath. At the end of the cycle, `out_char` ← `enc_out` and `out_valid` ← 1. Go to IDLE.
- **Wrap:** an increment from ALPHA-1 gives 0. Arithmetic is 5-bit with an explicit compare-and-clear; no modulo operator.
- **Requests while busy:** `key_valid` or `cfg_load` in STEP or ENC is dropped, `err` pulses, and the rotors are untouched.
- **Reset:** state IDLE. r1=r2=r3=0, `enc_in`=0, `out_char`=0, `out_valid`=0, `err`=0, `busy`=0. Reset mid-operation abandons the letter and produces no `out_valid`.

## Timing

- `key_valid` sampled at edge k (IDLE):
  - edge k: `busy`=1.
  - edge k+1: rotors stepped.
  - edge k+2: `out_valid`=1 and `out_char` valid for one cycle; `busy`=0.
- The next `key_valid` may be accepted at edge k+3. That is the cycle in which `out_valid` is high, since the FSM is already back in IDLE.
- `cfg_load` takes effect on the sampling edge. New positions are visible the next cycle.
- `err` is registered and pulses one cycle after the offending request.
- The datapath is purely combinational. One full ENC cycle covers its settling; no multicycle path exists.

## Structure

- Package `enigma_pkg`:
  - `LETTER_W`=5, `ALPHA`=26.
  - Default notch constants.
  - FSM state enum (IDLE, STEP, ENC).
- Sub-module `rotor_stepper`: purely combinational.
  - Inputs: r1..r3. Outputs: next r1..r3.
  - Implements the increment, wrap and double-step rules.
  - Testable alone.
- The `encryption` datapath is instantiated beside this block at the top level, not inside it.

## Test plan

- **Reset:** `rst` for 2 cycles → all outputs 0, `busy`=0. Load (0,0,0), key 0 → rotors (1,0,0); `out_valid` exactly 2 edges after acceptance; `out_char` equals `enc_out` for letter 0 at (1,0,0).
- **Notch carry:** load (16,0,0), key 5 → rotors (17,1,0). Load (15,0,0), key 5 → rotors (16,0,0), no carry.
- **Double-step:** load (16,3,0):
  - key → (17,4,0).
  - key → (18,5,1).
  - key → (19,5,1).
- **Wrap:** load (25,25,25), key → (0,25,25). Load (16,4,25), key → (17,5,0).
- **Rejects:**
  - `key_in`=26 → `err` pulse, rotors unchanged, no `out_valid`.
  - `cfg_r2`=30 → `err`, positions unchanged.
  - `key_valid` during STEP → `err`, exactly one `out_valid`.
  - `cfg_load`+`key_valid` together → load applied, key dropped, `err`.
- **Reset mid-operation:** assert `rst` in STEP → next cycle rotors (0,0,0), `out_valid` never asserts, `busy`=0.
